// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and bit-period helper.
// Used by both uart_tx and uart_rx so the two ends of the link agree.
package uart_pkg;

  // Frame phases, common to transmitter and receiver.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_e;

  // Number of clock cycles per serial bit (integer division, rounds down).
  function automatic int clks_per_bit(input int clk_freq, input int bit_rate);
    return clk_freq / bit_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps,
// pulsing o_tick on the last count. Held at 0 while disabled, so every
// enabled run starts a full bit period from its first cycle.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_tick;

  // Tick is combinational so the owner can act on the same edge the count wraps.
  assign w_tick = i_enable && (r_count == LAST_COUNT);
  assign o_tick = w_tick;

  // Count while enabled, wrap on the tick, clear whenever disabled or reset.
  always_ff @(posedge clk) begin
    if (reset || !i_enable) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. Accepts one word over a valid/ready handshake and sends
// it as start bit (0), PAYLOAD_BITS data bits LSB first, STOP_BITS stop bits (1),
// each lasting CLKS_PER_BIT clocks. The serial line is a register output.
//
// Handshake: a word is taken on a rising edge where i_valid && o_ready.
// o_ready is high in IDLE, and also in the very last cycle of the final stop
// bit, so a producer holding i_valid gets its next start bit immediately after
// the previous stop bit with no idle gap. i_valid while not ready is ignored.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_FREQ     = 10_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  input  logic [PAYLOAD_BITS-1:0] i_data,
  output logic                    o_ready,
  output logic                    o_serial_data,
  output logic                    o_busy,
  output logic                    o_tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BIT_RATE);
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_CNT_W    = $clog2(PAYLOAD_BITS) + 1;

  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);

  // Reject parameter sets that cannot produce a valid frame.
  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLK_FREQ / BIT_RATE must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PAYLOAD_BITS < 1) begin : g_payload_check
    $error("uart_tx: PAYLOAD_BITS must be at least 1");
  end

  uart_state_e              r_state;
  logic [PAYLOAD_BITS-1:0]  r_shift;
  logic [BIT_CNT_W-1:0]     r_bit_cnt;
  logic                     r_serial;
  logic                     r_busy;
  logic                     r_tx_done;

  logic                     w_tick;
  logic                     w_timer_en;
  logic                     w_final_tick;
  logic                     w_accept;
  logic [PAYLOAD_BITS-1:0]  w_shift_next;

  // Bit timer runs for the whole frame and is held at 0 in IDLE.
  assign w_timer_en = (r_state != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (TIMER_W)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_timer_en),
    .o_tick   (w_tick)
  );

  // Last cycle of the last stop bit: the frame ends on this edge.
  assign w_final_tick = (r_state == STOP_BIT) && w_tick && (r_bit_cnt == LAST_STOP_BIT);

  // Ready in IDLE or on the closing edge of a frame; never while reset is high.
  assign o_ready  = !reset && ((r_state == IDLE) || w_final_tick);
  assign w_accept = i_valid && o_ready;

  assign w_shift_next = r_shift >> 1;

  // Frame sequencer: state, shift register, bit counter and all line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_serial  <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          if (w_accept) begin
            r_shift  <= i_data;
            r_state  <= START_BIT;
            r_serial <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        START_BIT: begin
          if (w_tick) begin
            r_state   <= DATA_BITS;
            r_serial  <= r_shift[0];
            r_bit_cnt <= '0;
          end
        end

        DATA_BITS: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_DATA_BIT) begin
              r_state   <= STOP_BIT;
              r_serial  <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_shift   <= w_shift_next;
              r_serial  <= w_shift_next[0];
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        STOP_BIT: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_STOP_BIT) begin
              r_tx_done <= 1'b1;
              r_bit_cnt <= '0;
              if (w_accept) begin
                // Next word starts its start bit right where this stop bit ends.
                r_shift  <= i_data;
                r_state  <= START_BIT;
                r_serial <= 1'b0;
                r_busy   <= 1'b1;
              end else begin
                r_state  <= IDLE;
                r_serial <= 1'b1;
                r_busy   <= 1'b0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        default: begin
          r_state  <= IDLE;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_serial_data = r_serial;
  assign o_busy        = r_busy;
  assign o_tx_done     = r_tx_done;

endmodule
